btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Upstream stage of the player rectangle mover: turns four raw, asynchronous push-button inputs into clean one-cycle move commands.
- Per button: synchronises, then debounces. Across buttons: priority-encodes to a single one-hot code (8=U, 4=D, 2=R, 1=L), then auto-repeats while a button is held.
- Output `btns` drives the mover's `btns` input. `clk` is the mover's `btnClk`.

Parameters:
- CNT_W, 32, width of all internal counters.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed before a debounced level changes.
- REPEAT_DELAY, 25000000, cycles from the first move pulse to the second while the button is held.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses.

Ports:
- clk  in  1  system clock (same clock as the mover's btnClk).
- rst  in  1  reset; synchronous, active-low.
- btns_raw  in  4  raw buttons, bit3=U, bit2=D, bit1=R, bit0=L; asynchronous, bouncy.
- hold  in  1  1 = suppress all move pulses (player disabled / frozen).
- btns  out  4  registered one-hot move command, valid for exactly one cycle; 0 otherwise.
- move_tick  out  1  registered; equals |btns.
- btn_state  out  2  FSM state for debug: 0=IDLE, 1=DELAY, 2=REPEAT.

Behaviour:
- Reset (rst=0 at a rising clk edge):
  - Sync flops, debounced levels, counters and latched code all go to 0.
  - FSM goes to IDLE; btns=0, move_tick=0, btn_state=0.
  - Reset held for any number of cycles, including mid-DELAY or mid-REPEAT, discards all history.
- Synchroniser: two flops per bit; s2 is the synchronised level.
- Debounce, per bit independently:
  - A counter increments while s2 != deb and clears to 0 whenever s2 == deb.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, deb takes s2 and the counter clears.
  - Result: a glitch shorter than DEBOUNCE_CYCLES never changes deb. Both press and release are debounced.
- Select (combinational from deb): priority U > D > R > L, output one-hot; sel=0 if no bit is set.
- FSM; cnt is CNT_W bits; cur is the latched code:
  - IDLE: if hold=0 and sel!=0, then btns<=sel, cur<=sel, cnt<=0, go to DELAY. Otherwise btns<=0.
  - DELAY:
    - if hold=1 or sel!=cur, then go to IDLE with btns<=0. A changed nonzero sel is emitted on the next cycle from IDLE.
    - else if cnt==REPEAT_DELAY-1, then btns<=cur, cnt<=0, go to REPEAT.
    - else cnt<=cnt+1.
  - REPEAT: same as DELAY, but the limit is REPEAT_PERIOD-1 and the state stays REPEAT after each pulse.
- Pulse spacing while one button is held: first→second pulse = REPEAT_DELAY cycles; every later pulse = REPEAT_PERIOD cycles.
- Latency: btns rises DEBOUNCE_CYCLES+3 edges after the first edge that samples btns_raw high (2 sync + debounce + 1 output register).
- Simultaneous presses: only the highest-priority bit is ever output; btns is never multi-hot.
- hold released while a button is still held: next cycle IDLE emits an immediate first pulse; the repeat timing restarts.
- Counters never wrap in normal operation: both limits must be < 2^CNT_W, which is a parameter check only.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. btns_raw=4'b1000 held 40 cycles from edge 1, then released -> btns=8 for one cycle at edge 7, then at edges 17, 20, 23, …; move_tick mirrors btns; btns=0 after release plus debounce.
2. btns_raw bit1 high for 3 cycles then low (glitch) -> btns stays 0 throughout; btn_state stays 0.
3. btns_raw=4'b1001 (U+L) held -> only btns=8 pulses; btns never equals 1 or 9.
4. Hold L (pulses 1); mid-REPEAT also press D -> after debounce, one cycle with btns=0 (DELAY/REPEAT→IDLE), then btns=4; repeat timing restarts from that pulse.
5. Button R held with hold=1 -> no pulses; drop hold -> btns=2 on the second edge after hold falls, next pulse REPEAT_DELAY cycles later.
6. rst=0 for 1 cycle during REPEAT with U held -> btns=0, btn_state=0 the next cycle; the first new pulse comes DEBOUNCE_CYCLES+3 edges after rst returns high.

Source files
------------

// File: rtl/btn_conditioner.sv
// Button conditioner: four raw push-buttons in, one-cycle one-hot move
// commands out. Each bit is synchronised and debounced on its own; the
// debounced set is priority-encoded (U > D > R > L) and auto-repeated
// while held.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no move in progress; first pulse issued as soon as allowed
// DELAY  | first pulse issued, waiting REPEAT_DELAY cycles for repeat
// REPEAT | repeating every REPEAT_PERIOD cycles while code is unchanged
module btn_conditioner #(
    parameter int CNT_W           = 32,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btns_raw,
    input  logic       hold,
    output logic [3:0] btns,
    output logic       move_tick,
    output logic [1:0] btn_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    // Limits must fit the counters, otherwise a terminal count is never hit.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        $clog2(DEBOUNCE_CYCLES) > CNT_W || $clog2(REPEAT_DELAY) > CNT_W ||
        $clog2(REPEAT_PERIOD) > CNT_W) begin : g_bad_params
        $error("btn_conditioner: counter limits out of range for CNT_W");
    end

    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       deb;
    logic [CNT_W-1:0] dcnt [4];
    logic [3:0]       sel;
    logic [3:0]       cur;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    // Two-flop synchroniser per button bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btns_raw;
            s2 <= s2_next(s1);
        end
    end

    function automatic logic [3:0] s2_next(input logic [3:0] v);
        return v;
    endfunction

    // Per-bit debounce: level changes only after a full run of mismatches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            deb <= '0;
            for (int i = 0; i < 4; i++) dcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_LAST) begin
                    deb[i]  <= s2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Priority select of the debounced buttons, one-hot result.
    always_comb begin
        sel = 4'b0000;
        if (deb[3])      sel = 4'b1000;
        else if (deb[2]) sel = 4'b0100;
        else if (deb[1]) sel = 4'b0010;
        else if (deb[0]) sel = 4'b0001;
    end

    // Pulse / auto-repeat sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cur       <= '0;
            cnt       <= '0;
            btns      <= '0;
            move_tick <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hold && sel != 4'b0000) begin
                        btns      <= sel;
                        move_tick <= 1'b1;
                        cur       <= sel;
                        cnt       <= '0;
                        state     <= DELAY;
                    end else begin
                        btns      <= '0;
                        move_tick <= 1'b0;
                    end
                end
                DELAY, REPEAT: begin
                    // A changed code goes back through IDLE so it gets a fresh first pulse.
                    if (hold || sel != cur) begin
                        btns      <= '0;
                        move_tick <= 1'b0;
                        state     <= IDLE;
                    end else if (cnt == ((state == DELAY) ? RD_LAST : RP_LAST)) begin
                        btns      <= cur;
                        move_tick <= 1'b1;
                        cnt       <= '0;
                        state     <= REPEAT;
                    end else begin
                        btns      <= '0;
                        move_tick <= 1'b0;
                        cnt       <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    btns      <= '0;
                    move_tick <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign btn_state = state;

endmodule
